// File: rtl/ssbus_if.sv
`default_nettype none
// ============================================================================
//  Module   : ssbus_if
//  Purpose  : Savestate bus connecting the sequencer (master) to the slaves.
//             The master owns select/addr/data_out and the query/read/write
//             strobes. The slave answers with data_in and a one-cycle ack.
//  Revision : 1.0  initial release
// ============================================================================
interface ssbus_if;
    logic [7:0]  select;
    logic [23:0] addr;
    logic [63:0] data_out;
    logic [63:0] data_in;
    logic        query;
    logic        read;
    logic        write;
    logic        ack;

    modport master (
        output select, addr, data_out, query, read, write,
        input  data_in, ack
    );

    modport slave (
        input  select, addr, data_out, query, read, write,
        output data_in, ack
    );
endinterface
`default_nettype wire

// File: rtl/ss_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ss_sequencer
//  Purpose  : Savestate bus initiator. Walks every slave index, then either
//             dumps the slave words (behind a header word) to a 64-bit memory
//             window, or reads them back, validates the header and writes
//             them into the slave.
//  Revision : 1.0  initial release
// ============================================================================
module ss_sequencer #(
    parameter int          NUM_SLAVES = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          TIMEOUT    = 255
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    input  wire logic        start_save,
    input  wire logic        start_restore,
    output logic             busy,
    output logic             done,
    output logic             error,
    ssbus_if.master          ssbus,
    output logic [31:0]      mem_addr,
    output logic [63:0]      mem_wdata,
    input  wire logic [63:0] mem_rdata,
    output logic             mem_wr,
    output logic             mem_rd,
    input  wire logic        mem_ready
);

    localparam logic [7:0]  c_LAST_IDX = 8'(NUM_SLAVES - 1);
    localparam logic [31:0] c_TMO_LAST = 32'(TIMEOUT - 1);
    localparam logic [15:0] c_MAGIC    = 16'h5353;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_QUERY  = 4'd1,
        S_HDR    = 4'd2,
        S_BUS_RD = 4'd3,
        S_MEM_WR = 4'd4,
        S_MEM_RD = 4'd5,
        S_BUS_WR = 4'd6,
        S_NEXT   = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t      r_state, w_next;
    logic        r_restore, w_restore;
    logic [7:0]  r_idx, w_idx;
    logic [31:0] r_ptr, w_ptr;
    logic [23:0] r_waddr, w_waddr;
    logic [31:0] r_count, w_count;
    logic [63:0] r_data, w_data;
    logic        r_error, w_error;
    logic [31:0] r_tmo;

    logic [63:0] w_hdr;
    logic [23:0] w_waddr_inc;
    logic        w_last_word;
    logic        w_tmo_hit;
    logic        w_unused_hi;

    // Header layout: magic, zero byte, slave index, word count
    assign w_hdr       = {c_MAGIC, 8'h00, r_idx, r_count};
    assign w_waddr_inc = r_waddr + 24'd1;
    // Word address is 24 bits wide, so only the low bits of the count matter
    assign w_last_word = (w_waddr_inc == r_count[23:0]);
    assign w_tmo_hit   = (r_tmo == c_TMO_LAST);
    assign w_unused_hi = ^ssbus.data_in[63:32];

    // State register and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_restore <= 1'b0;
            r_idx     <= 8'd0;
            r_ptr     <= 32'd0;
            r_waddr   <= 24'd0;
            r_count   <= 32'd0;
            r_data    <= 64'd0;
            r_error   <= 1'b0;
            r_tmo     <= 32'd0;
        end else begin
            r_state   <= w_next;
            r_restore <= w_restore;
            r_idx     <= w_idx;
            r_ptr     <= w_ptr;
            r_waddr   <= w_waddr;
            r_count   <= w_count;
            r_data    <= w_data;
            r_error   <= w_error;
            // Ack timer restarts on every state change, counts while waiting
            r_tmo     <= (w_next != r_state) ? 32'd0 : r_tmo + 32'd1;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        w_next    = r_state;
        w_restore = r_restore;
        w_idx     = r_idx;
        w_ptr     = r_ptr;
        w_waddr   = r_waddr;
        w_count   = r_count;
        w_data    = r_data;
        w_error   = r_error;
        case (r_state)
            S_IDLE: begin
                if (start_save || start_restore) begin
                    // Save has priority when both pulse together
                    w_restore = ~start_save;
                    w_error   = 1'b0;
                    w_idx     = 8'd0;
                    w_ptr     = BASE_ADDR;
                    w_waddr   = 24'd0;
                    w_next    = S_QUERY;
                end
            end
            S_QUERY: begin
                if (ssbus.ack) begin
                    w_count = ssbus.data_in[31:0];
                    w_waddr = 24'd0;
                    w_next  = (ssbus.data_in[31:0] == 32'd0) ? S_NEXT : S_HDR;
                end else if (w_tmo_hit) begin
                    // Absent slave: skipped silently, no header written
                    w_count = 32'd0;
                    w_next  = S_NEXT;
                end
            end
            S_HDR: begin
                if (mem_ready) begin
                    if (!r_restore) begin
                        w_ptr  = r_ptr + 32'd8;
                        w_next = S_BUS_RD;
                    end else if (mem_rdata == w_hdr) begin
                        w_ptr  = r_ptr + 32'd8;
                        w_next = S_MEM_RD;
                    end else begin
                        w_error = 1'b1;
                        w_next  = S_DONE;
                    end
                end
            end
            S_BUS_RD: begin
                if (ssbus.ack) begin
                    w_data = ssbus.data_in;
                    w_next = S_MEM_WR;
                end else if (w_tmo_hit) begin
                    w_error = 1'b1;
                    w_next  = S_DONE;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    w_ptr   = r_ptr + 32'd8;
                    w_waddr = w_waddr_inc;
                    w_next  = w_last_word ? S_NEXT : S_BUS_RD;
                end
            end
            S_MEM_RD: begin
                if (mem_ready) begin
                    w_data = mem_rdata;
                    w_ptr  = r_ptr + 32'd8;
                    w_next = S_BUS_WR;
                end
            end
            S_BUS_WR: begin
                if (ssbus.ack) begin
                    w_waddr = w_waddr_inc;
                    w_next  = w_last_word ? S_NEXT : S_MEM_RD;
                end else if (w_tmo_hit) begin
                    w_error = 1'b1;
                    w_next  = S_DONE;
                end
            end
            S_NEXT: begin
                w_idx  = r_idx + 8'd1;
                w_next = (r_idx == c_LAST_IDX) ? S_DONE : S_QUERY;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Outputs decode straight from the state register so that reset clears
    // every strobe immediately and each strobe drops the cycle after its ack
    always_comb begin
        busy           = (r_state != S_IDLE) && (r_state != S_DONE);
        done           = (r_state == S_DONE) && !r_error;
        error          = r_error;
        ssbus.select   = r_idx;
        ssbus.addr     = r_waddr;
        ssbus.data_out = r_data;
        ssbus.query    = (r_state == S_QUERY);
        ssbus.read     = (r_state == S_BUS_RD);
        ssbus.write    = (r_state == S_BUS_WR);
        mem_addr       = {r_ptr[31:3], 3'b000};
        mem_wdata      = (r_state == S_HDR) ? w_hdr : r_data;
        mem_wr         = ((r_state == S_HDR) && !r_restore) || (r_state == S_MEM_WR);
        mem_rd         = ((r_state == S_HDR) &&  r_restore) || (r_state == S_MEM_RD);
    end

endmodule
`default_nettype wire

// File: tb/tb_ss_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ss_sequencer
//  Purpose  : Self-checking bench for ss_sequencer. Behavioural slave and
//             memory responders with random latency; a reference model
//             pushes expected memory writes, bus writes and completion status
//             into a queue that a monitor pops as the DUT produces them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ss_sequencer;

    localparam int          NS   = 4;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          TMO  = 20;

    localparam int K_MEMW = 0;
    localparam int K_BUSW = 1;
    localparam int K_END  = 2;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [63:0] d;
    } ev_t;

    logic        clk;
    logic        reset_n;
    logic        start_save;
    logic        start_restore;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_wr;
    logic        mem_rd;
    logic        mem_ready;

    ssbus_if bus ();

    ss_sequencer #(
        .NUM_SLAVES (NS),
        .BASE_ADDR  (BASE),
        .TIMEOUT    (TMO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start_save    (start_save),
        .start_restore (start_restore),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .ssbus         (bus),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_wr        (mem_wr),
        .mem_rd        (mem_rd),
        .mem_ready     (mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment state
    int          total = 0;
    int          bad   = 0;
    int          done_cnt = 0;
    int          wr_acks  = 0;
    bit          mon_en   = 1'b1;
    bit          present [NS];
    int          cnt     [NS];
    int          stall   [NS];
    logic [63:0] regs    [NS][32];
    logic [63:0] gold    [NS][32];
    logic [63:0] mem     [logic [31:0]];
    ev_t         exp_q   [$];

    function automatic logic [63:0] hdr(input int i, input int c);
        return {16'h5353, 8'h00, 8'(i), 32'(c)};
    endfunction

    function automatic logic [63:0] memrd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 64'd0;
    endfunction

    function automatic void push(input int k, input logic [31:0] a, input logic [63:0] d);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.d    = d;
        exp_q.push_back(e);
    endfunction

    // Expected save image: one header + words per responding slave with a
    // non-zero count, packed back to back from BASE
    function automatic void model_save();
        logic [31:0] p;
        p = BASE;
        for (int i = 0; i < NS; i++) begin
            if (present[i] && cnt[i] != 0) begin
                push(K_MEMW, p, hdr(i, cnt[i]));
                p += 32'd8;
                for (int a = 0; a < cnt[i]; a++) begin
                    if (stall[i] == a) begin
                        push(K_END, 32'd0, 64'd1);
                        return;
                    end
                    push(K_MEMW, p, regs[i][a]);
                    p += 32'd8;
                end
            end
        end
        push(K_END, 32'd0, 64'd2);
    endfunction

    // Expected restore: headers must match the re-queried count and index
    function automatic void model_restore();
        logic [31:0] p;
        p = BASE;
        for (int i = 0; i < NS; i++) begin
            if (present[i] && cnt[i] != 0) begin
                if (memrd(p) != hdr(i, cnt[i])) begin
                    push(K_END, 32'd0, 64'd1);
                    return;
                end
                p += 32'd8;
                for (int a = 0; a < cnt[i]; a++) begin
                    push(K_BUSW, {8'(i), 24'(a)}, memrd(p));
                    p += 32'd8;
                end
            end
        end
        push(K_END, 32'd0, 64'd2);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic check_ev(input int k, input logic [31:0] a, input logic [63:0] d, input string nm);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected event a=%h d=%h", nm, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.a !== a || e.d !== d) begin
                bad++;
                $display("FAIL %s: got kind=%0d a=%h d=%h expected kind=%0d a=%h d=%h",
                         nm, k, a, d, e.kind, e.a, e.d);
            end
        end
    endtask

    // Slave responder: ack after a random 0..4 cycle delay
    initial begin
        int bdly;
        int s;
        bdly = -1;
        bus.ack = 1'b0;
        bus.data_in = 64'd0;
        forever begin
            @(posedge clk);
            #1;
            bus.ack = 1'b0;
            if (!(bus.query || bus.read || bus.write)) begin
                bdly = -1;
            end else begin
                if (bdly < 0) bdly = int'($urandom_range(0, 4));
                if (bdly == 0) begin
                    s = int'(bus.select);
                    if (s < NS && present[s] && !(bus.read && stall[s] == int'(bus.addr))) begin
                        bus.ack = 1'b1;
                        bdly = -1;
                        if (bus.query) bus.data_in = {32'd0, 32'(cnt[s])};
                        if (bus.read)  bus.data_in = regs[s][bus.addr[4:0]];
                        if (bus.write) begin
                            regs[s][bus.addr[4:0]] = bus.data_out;
                            wr_acks++;
                        end
                    end
                end else begin
                    bdly--;
                end
            end
        end
    end

    // Memory responder: one-cycle ready after a random 0..3 cycle delay
    initial begin
        int mdly;
        mdly = -1;
        mem_ready = 1'b0;
        mem_rdata = 64'd0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (!(mem_wr || mem_rd)) begin
                mdly = -1;
            end else begin
                if (mdly < 0) mdly = int'($urandom_range(0, 3));
                if (mdly == 0) begin
                    mem_ready = 1'b1;
                    mdly = -1;
                    if (mem_wr) mem[mem_addr] = mem_wdata;
                    else        mem_rdata = memrd(mem_addr);
                end else begin
                    mdly--;
                end
            end
        end
    end

    // Monitor: compare every completed DUT transaction against the queue
    initial begin
        bit prev_busy;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (mem_wr && mem_ready)
                    check_ev(K_MEMW, mem_addr, mem_wdata, "memwr");
                if (bus.write && bus.ack)
                    check_ev(K_BUSW, {bus.select, bus.addr}, bus.data_out, "buswr");
                if (prev_busy && !busy)
                    check_ev(K_END, 32'd0, {62'd0, done, error}, "end");
            end
            if (done) done_cnt++;
            prev_busy = busy;
        end
    end

    task automatic run_seq(input bit sv, input bit rs, input bit mid, input string nm);
        bit ok;
        @(posedge clk);
        #1;
        start_save = sv;
        start_restore = rs;
        @(posedge clk);
        #1;
        start_save = 1'b0;
        start_restore = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            if (mid && c == 30) begin
                #1 start_restore = 1'b1;
                @(posedge clk);
                #1 start_restore = 1'b0;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_timeout: busy still %0d expected 0", nm, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_leftover"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic clear_slaves();
        for (int i = 0; i < NS; i++) begin
            present[i] = 1'b0;
            cnt[i] = 0;
            stall[i] = -1;
            for (int a = 0; a < 32; a++) regs[i][a] = 64'd0;
        end
    endtask

    initial begin
        int d0;
        start_save = 1'b0;
        start_restore = 1'b0;
        reset_n = 1'b0;
        clear_slaves();
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy",   64'(busy),      64'd0);
        chk("rst_done",   64'(done),      64'd0);
        chk("rst_error",  64'(error),     64'd0);
        chk("rst_mem_wr", 64'(mem_wr),    64'd0);
        chk("rst_mem_rd", 64'(mem_rd),    64'd0);
        chk("rst_query",  64'(bus.query), 64'd0);
        chk("rst_read",   64'(bus.read),  64'd0);
        chk("rst_write",  64'(bus.write), 64'd0);
        chk("rst_addr",   64'(mem_addr),  64'd0);
        reset_n = 1'b1;

        // Save: only slave 1 responds with 16 words of value 1..16
        present[1] = 1'b1;
        cnt[1] = 16;
        for (int a = 0; a < 16; a++) regs[1][a] = 64'(a + 1);
        d0 = done_cnt;
        model_save();
        run_seq(1'b1, 1'b0, 1'b0, "save16");
        chk("save16_hdr",  memrd(BASE), 64'h5353_0001_0000_0010);
        chk("save16_last", memrd(BASE + 32'd128), 64'd16);
        chk("save16_done", 64'(done_cnt - d0), 64'd1);

        // Restore that image into a zeroed slave
        for (int a = 0; a < 16; a++) regs[1][a] = 64'd0;
        wr_acks = 0;
        d0 = done_cnt;
        model_restore();
        run_seq(1'b0, 1'b1, 1'b0, "rest16");
        for (int a = 0; a < 16; a += 5) chk("rest16_reg", regs[1][a], 64'(a + 1));
        chk("rest16_acks", 64'(wr_acks), 64'd16);
        chk("rest16_done", 64'(done_cnt - d0), 64'd1);

        // Corrupted header index byte: error, no done, no bus write
        mem[BASE] = 64'h5353_0002_0000_0010;
        wr_acks = 0;
        d0 = done_cnt;
        model_restore();
        run_seq(1'b0, 1'b1, 1'b0, "corrupt");
        chk("corrupt_err",  64'(error), 64'd1);
        chk("corrupt_done", 64'(done_cnt - d0), 64'd0);
        chk("corrupt_acks", 64'(wr_acks), 64'd0);

        // Slave never acks the read of word 2
        cnt[1] = 4;
        stall[1] = 2;
        for (int a = 0; a < 4; a++) regs[1][a] = 64'(32'hA0 + a);
        d0 = done_cnt;
        model_save();
        run_seq(1'b1, 1'b0, 1'b0, "stall");
        chk("stall_err",  64'(error), 64'd1);
        chk("stall_done", 64'(done_cnt - d0), 64'd0);
        stall[1] = -1;

        // Asynchronous reset while writing data words
        cnt[1] = 16;
        mon_en = 1'b0;
        @(posedge clk);
        #1 start_save = 1'b1;
        @(posedge clk);
        #1 start_save = 1'b0;
        begin
            bit hit;
            hit = 1'b0;
            for (int c = 0; c < 2000; c++) begin
                @(negedge clk);
                if (mem_wr && mem_addr != BASE) begin
                    hit = 1'b1;
                    break;
                end
            end
            chk("rstmid_reach", 64'(hit), 64'd1);
        end
        #1 reset_n = 1'b0;
        #1;
        chk("rstmid_busy",   64'(busy),     64'd0);
        chk("rstmid_mem_wr", 64'(mem_wr),   64'd0);
        chk("rstmid_addr",   64'(mem_addr), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.delete();
        mon_en = 1'b1;
        model_save();
        run_seq(1'b1, 1'b0, 1'b0, "after_rst");

        // Both starts together, then a restore pulse mid-save
        d0 = done_cnt;
        model_save();
        run_seq(1'b1, 1'b1, 1'b1, "both");
        chk("both_done", 64'(done_cnt - d0), 64'd1);

        // Random slave populations: save then restore into zeroed slaves
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < NS; i++) begin
                present[i] = $urandom_range(0, 1) != 0;
                cnt[i] = int'($urandom_range(0, 6));
                stall[i] = -1;
                for (int a = 0; a < 32; a++) regs[i][a] = {$urandom, $urandom};
            end
            model_save();
            run_seq(1'b1, 1'b0, 1'b0, "rnd_save");
            for (int i = 0; i < NS; i++)
                for (int a = 0; a < 32; a++) begin
                    gold[i][a] = regs[i][a];
                    regs[i][a] = 64'd0;
                end
            model_restore();
            run_seq(1'b0, 1'b1, 1'b0, "rnd_rest");
            for (int i = 0; i < NS; i++)
                if (present[i])
                    for (int a = 0; a < cnt[i]; a++)
                        chk("rnd_reg", regs[i][a], gold[i][a]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ss_sequencer.md
Name: ss_sequencer

Overview:
- Savestate bus initiator. Sequences save and restore of all ssbus slaves (priority mixers, register banks, RAM shadows) to and from a 64-bit memory window.
- On save: queries each slave index for its word count, writes a header word plus every slave word to memory.
- On restore: reads the header, validates it, and writes the words back into the slave.
- Sits between the top-level save/load controls and the SDRAM/DDR arbiter port.

Parameters:
- NUM_SLAVES, 32, number of slave indices walked (0..NUM_SLAVES-1)
- BASE_ADDR, 32'h0, byte address of the first header in memory
- TIMEOUT, 255, cycles to wait for any slave ack before declaring absence or error

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start_save  in  1  one-cycle pulse; begin save when idle
- start_restore  in  1  one-cycle pulse; begin restore when idle
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at successful completion
- error  out  1  sticky until next start; restore header mismatch or slave timeout
- ssbus  master  ssbus_if.master  savestate bus; fields used: select[7:0], addr[23:0], data_out[63:0], data_in[63:0], query, read, write, ack
- mem_addr  out  32  byte address, always 8-byte aligned
- mem_wdata  out  64  write data
- mem_rdata  in  64  read data, valid with mem_ready on reads
- mem_wr  out  1  write request, held until mem_ready
- mem_rd  out  1  read request, held until mem_ready
- mem_ready  in  1  one-cycle completion strobe

Behaviour:
- Reset (async, reset_n=0): FSM to IDLE. busy, done, error, mem_wr, mem_rd, query, read and write all 0. Address and index counters 0.
- start_save and start_restore are ignored when not IDLE. If both pulse in the same cycle, save wins.
- A start clears error, sets slave index to 0, mem pointer to BASE_ADDR, and asserts busy the next cycle.
- States: IDLE, QUERY, HDR, BUS_RD, MEM_WR, MEM_RD, BUS_WR, NEXT, DONE.
- QUERY: drive select=idx and query=1 until ack.
  - Slave count = data_in[31:0] at ack.
  - No ack within TIMEOUT cycles: count=0, slave skipped with no header, no error.
  - count=0 (by ack or by timeout): go to NEXT.
- HDR (save):
  - mem_wr with wdata={16'h5353, 8'h00, idx[7:0], count[31:0]}.
  - On mem_ready: pointer+=8, word addr=0, go to BUS_RD.
- HDR (restore):
  - mem_rd at pointer. On mem_ready, compare rdata against the same format.
  - Mismatch: error=1, go to DONE without done pulse.
  - Match: pointer+=8, go to MEM_RD.
- BUS_RD: read=1, addr=word addr, select=idx until ack. Latch data_in, go to MEM_WR.
- MEM_WR: write latched word. On mem_ready: pointer+=8, addr+=1. If addr==count go to NEXT, else go to BUS_RD.
- MEM_RD / BUS_WR:
  - Symmetric to BUS_RD / MEM_WR.
  - BUS_WR holds write=1 and data_out until ack.
  - Advance on ack.
- Ack timeouts during BUS_RD/BUS_WR: error=1, go to DONE.
- Handshakes: the bus strobe (query/read/write) drops in the cycle after ack. No back-to-back strobe without at least one idle cycle. mem_wr/mem_rd drop the cycle after mem_ready.
- NEXT: idx+=1. If idx==NUM_SLAVES-1 before increment go to DONE, else go to QUERY.
- DONE:
  - busy=0.
  - done=1 for one cycle only if error==0.
  - Then IDLE.
- Widths and wrap:
  - Word addr is 24 bits; count >2^24 is truncated, no error.
  - Pointer wraps modulo 2^32, no error.
- Restore uses query to re-learn count and also checks it against the stored header (the header compare covers count).
- reset_n assertion mid-sequence aborts immediately with no completion pulse. A memory transaction in flight is abandoned; the arbiter tolerates a dropped request.

Test Plan:
- Save with NUM_SLAVES=4: slave 1 has count=16 (TC0360PRI-like, ctrl[i]=i+1), slaves 0/2/3 never ack. Expect:
  - single header 5353_0001_0000_0010 at BASE_ADDR;
  - 16 words of values 1..16 at BASE+8..BASE+128;
  - done pulse; error=0.
- Restore of that image into a slave reset to zero → slave registers read back 1..16; done pulse; 16 write acks observed.
- Restore with the header byte idx corrupted to 02 → error=1, no done, no bus write issued, busy drops within 2 cycles.
- Slave acks the query with count=4 but never acks the read of addr 2 → error after TIMEOUT cycles; mem holds header plus 2 words.
- reset_n pulsed low while in MEM_WR → busy=0 and mem_wr=0 asynchronously; a later start_save runs cleanly from BASE_ADDR.
- start_save and start_restore in the same cycle, then start_restore mid-save → save runs, the second start is ignored, one done pulse.
